// File: rtl/bitmap_fetch_arbiter.sv
// Streams a 1-bpp bitmap from a shared single-port frame RAM into one pixel bit per clock,
// prefetching a byte ahead of pixel_x and lending idle RAM cycles to a write requester.
module bitmap_fetch_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int ADDR_W   = 16
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic              serial_output
);

  localparam int          BYTES_PER_LINE  = H_ACTIVE / 8;
  localparam logic [31:0] FB_BYTES        = 32'(V_ACTIVE * H_ACTIVE / 8);
  localparam logic [9:0]  X_LAST_COL_SLOT = 10'(H_ACTIVE - 8);
  localparam logic [9:0]  X_LINE_SLOT     = 10'(H_TOTAL - 3);
  localparam logic [9:0]  Y_ACTIVE        = 10'(V_ACTIVE);
  localparam logic [9:0]  Y_LAST          = 10'(V_TOTAL - 1);

  logic [1:0]        pend;
  logic [7:0]        prefetch;
  logic [7:0]        shift_reg;
  logic              armed;
  logic [9:0]        next_y;
  logic [9:0]        fetch_col;
  logic              col_slot;
  logic              line_slot;
  logic              fetch_slot;
  logic              wr_grant;
  logic              wr_in_range;
  logic [ADDR_W-1:0] fetch_addr;

  function automatic logic [ADDR_W-1:0] byte_addr(input logic [9:0] y, input logic [9:0] col);
    return ADDR_W'(y) * ADDR_W'(BYTES_PER_LINE) + ADDR_W'(col);
  endfunction

  // Column slots stay disabled after reset until a column-0 fetch re-aligns the pipeline
  always_comb begin
    next_y      = (pixel_y == Y_LAST) ? 10'd0 : pixel_y + 10'd1;
    fetch_col   = {3'b000, pixel_x[9:3]} + 10'd1;
    col_slot    = armed && (pixel_x[2:0] == 3'd5) && (pixel_x < X_LAST_COL_SLOT) &&
                  (pixel_y < Y_ACTIVE);
    line_slot   = (pixel_x == X_LINE_SLOT) && (next_y < Y_ACTIVE);
    fetch_slot  = col_slot || line_slot;
    fetch_addr  = line_slot ? byte_addr(next_y, 10'd0) : byte_addr(pixel_y, fetch_col);
    wr_grant    = wr_req && !fetch_slot && !wr_ack;
    wr_in_range = 32'(wr_addr) < FB_BYTES;
  end

  // RAM port owner for the next cycle; the ack register doubles as the write turnaround
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      wr_ack    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      wr_ack <= 1'b0;
      if (fetch_slot) begin
        mem_addr <= fetch_addr;
      end else if (wr_grant) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
        mem_we    <= wr_in_range;
        wr_ack    <= 1'b1;
      end
    end
  end

  // pend[0] marks the data-valid cycle, pend[1] the load cycle of the same fetch
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pend      <= 2'b00;
      prefetch  <= 8'h00;
      shift_reg <= 8'h00;
      armed     <= 1'b0;
    end else begin
      pend <= {pend[0], fetch_slot};
      if (pend[0] && (pixel_x[2:0] == 3'd6))
        prefetch <= mem_rdata;
      if (pixel_x[2:0] == 3'd7)
        shift_reg <= pend[1] ? prefetch : 8'h00;
      else
        shift_reg <= {shift_reg[6:0], 1'b0};
      if (pixel_x == X_LINE_SLOT)
        armed <= 1'b1;
    end
  end

  assign serial_output = shift_reg[7];

endmodule

// File: tb/tb_bitmap_fetch_arbiter.sv
// Directed bench for bitmap_fetch_arbiter: the bench drives pixel_x/pixel_y itself (jumping between
// lines to stay short) and models the frame RAM with a read that follows the registered address.
module tb_bitmap_fetch_arbiter;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        serial_output;

  logic [7:0]  ram [0:65535];
  logic        preload_en;
  logic [15:0] preload_addr;
  logic [7:0]  preload_data;

  int compared;
  int mismatched;

  bitmap_fetch_arbiter dut (
    .vga_clk       (vga_clk),
    .reset         (reset),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .serial_output (serial_output)
  );

  always #5 vga_clk = ~vga_clk;

  // Data for an address presented on one edge is sampled by the DUT on the next edge
  always @(posedge vga_clk) begin
    if (preload_en)
      ram[preload_addr] <= preload_data;
    else if (mem_we)
      ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One pixel clock; afterwards pixel_x/pixel_y name the cycle whose outputs are visible
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge vga_clk);
      #1;
      if (pixel_x == 10'd799) begin
        pixel_x = 10'd0;
        pixel_y = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
      end else begin
        pixel_x = pixel_x + 10'd1;
      end
    end
  endtask

  task automatic runTo(input int x, input int y);
    int steps;
    steps = 0;
    while (!(pixel_x == 10'(x) && pixel_y == 10'(y)) && steps < 5000) begin
      applyStimulus(1);
      steps++;
    end
    if (steps >= 5000)
      checkOutput($sformatf("runTo(%0d,%0d) budget", x, y), {12'd0, pixel_y, pixel_x},
                  {12'd0, 10'(y), 10'(x)});
  endtask

  task automatic preload(input int addr, input logic [7:0] data);
    preload_en   = 1'b1;
    preload_addr = 16'(addr);
    preload_data = data;
    @(posedge vga_clk);
    #1;
    preload_en = 1'b0;
  endtask

  // Expects pat[15] at the current pixel and one bit per following pixel
  task automatic checkPattern(input string tag, input logic [15:0] pat, input int count);
    for (int i = 0; i < count; i++) begin
      checkOutput($sformatf("%s y=%0d x=%0d", tag, pixel_y, pixel_x), 32'(serial_output),
                  32'(pat[15-i]));
      applyStimulus(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared     = 0;
    mismatched   = 0;
    reset        = 1'b1;
    pixel_x      = 10'd788;
    pixel_y      = 10'd524;
    wr_req       = 1'b0;
    wr_addr      = 16'd0;
    wr_data      = 8'h00;
    preload_en   = 1'b0;
    preload_addr = 16'd0;
    preload_data = 8'h00;

    preload(0, 8'hA5);
    preload(1, 8'h3C);
    preload(5, 8'h00);
    preload(6, 8'h00);
    preload(238, 8'h00);
    preload(239, 8'hFF);
    for (int c = 0; c < 80; c++) begin
      preload(38400 + c, 8'hFF);
      preload(800 + c, 8'hFF);
    end
    preload(880, 8'hC3);
    preload(881, 8'h5A);

    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("reset wr_ack", 32'(wr_ack), 32'd0);
    checkOutput("reset serial_output", 32'(serial_output), 32'd0);
    reset = 1'b0;

    // First frame start: column-0 fetch of line 0 at x=797 of line 524
    runTo(798, 524);
    checkOutput("wrap1 mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("wrap1 mem_we", 32'(mem_we), 32'd0);
    runTo(0, 0);
    checkPattern("line0 A5_3C", 16'hA53C, 16);

    // Last column of line 2 then blanking
    runTo(632, 2);
    checkPattern("line2 col79", 16'hFF00, 16);
    for (int x = 648; x < 800; x++) begin
      checkOutput($sformatf("line2 blank x=%0d", pixel_x), 32'(serial_output), 32'd0);
      applyStimulus(1);
    end

    // Write request raised during the column-2 fetch slot of line 3
    runTo(13, 3);
    wr_addr = 16'd5;
    wr_data = 8'h81;
    wr_req  = 1'b1;
    applyStimulus(1);
    checkOutput("slot mem_addr", 32'(mem_addr), 32'd242);
    checkOutput("slot mem_we", 32'(mem_we), 32'd0);
    checkOutput("slot wr_ack", 32'(wr_ack), 32'd0);
    applyStimulus(1);
    checkOutput("write mem_addr", 32'(mem_addr), 32'd5);
    checkOutput("write mem_wdata", 32'(mem_wdata), 32'h81);
    checkOutput("write mem_we", 32'(mem_we), 32'd1);
    checkOutput("write wr_ack", 32'(wr_ack), 32'd1);
    applyStimulus(1);
    wr_req = 1'b0;
    checkOutput("turnaround wr_ack", 32'(wr_ack), 32'd0);
    checkOutput("turnaround mem_we", 32'(mem_we), 32'd0);
    checkOutput("turnaround mem_addr", 32'(mem_addr), 32'd5);

    // Out-of-range write in blanking: acked but dropped
    runTo(700, 3);
    wr_addr = 16'd38400;
    wr_data = 8'h77;
    wr_req  = 1'b1;
    applyStimulus(1);
    checkOutput("drop wr_ack", 32'(wr_ack), 32'd1);
    checkOutput("drop mem_we", 32'(mem_we), 32'd0);
    applyStimulus(1);
    wr_req = 1'b0;
    checkOutput("drop turnaround wr_ack", 32'(wr_ack), 32'd0);
    checkOutput("drop turnaround mem_we", 32'(mem_we), 32'd0);
    applyStimulus(1);
    checkOutput("drop after mem_we", 32'(mem_we), 32'd0);

    // Line 479 must not fetch line 480 (which holds 0xFF bytes in the model)
    pixel_y = 10'd479;
    pixel_x = 10'd790;
    runTo(798, 479);
    checkOutput("no fetch 479 mem_we", 32'(mem_we), 32'd0);
    runTo(0, 480);
    checkPattern("line480 start", 16'h0000, 16);
    runTo(296, 480);
    checkPattern("line480 mid", 16'h0000, 12);

    // Frame wrap after mem_addr was last left at 38400
    pixel_y = 10'd524;
    pixel_x = 10'd790;
    runTo(798, 524);
    checkOutput("wrap2 mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("wrap2 mem_we", 32'(mem_we), 32'd0);
    runTo(0, 0);
    checkPattern("wrap2 line0", 16'hA500, 8);
    runTo(40, 0);
    checkPattern("written byte", 16'h8100, 8);

    // Reset in the middle of line 10 while 0xFF bytes are streaming
    pixel_y = 10'd10;
    pixel_x = 10'd280;
    runTo(300, 10);
    checkOutput("pre-reset serial_output", 32'(serial_output), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midline reset serial_output", 32'(serial_output), 32'd0);
    checkOutput("midline reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("midline reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("midline reset wr_ack", 32'(wr_ack), 32'd0);
    applyStimulus(3);
    reset = 1'b0;
    for (int x = 303; x < 800; x++) begin
      checkOutput($sformatf("after reset x=%0d", pixel_x), 32'(serial_output), 32'd0);
      applyStimulus(1);
    end
    checkPattern("line11 C3_5A", 16'hC35A, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
